// File: rtl/arm_pkg.sv
// Shared definitions for the ARM pipeline: machine widths, data-memory base
// address and the memory-stage sequencer states.
package arm_pkg;
    localparam int WORD_W     = 32;
    localparam int REG_ADDR_W = 4;
    localparam int DMEM_BASE  = 1024;

    typedef enum logic {IDLE, WAIT} mem_state_t;
endpackage

// File: rtl/dmem_array.sv
// Data-memory word array: synchronous write, asynchronous read, no reset.
module dmem_array #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
    end

    assign rdata = mem[addr];
endmodule

// File: rtl/mem_stage_ws.sv
// Memory stage with a configurable wait-state sequencer: stalls upstream via
// ready, performs the access on the completing edge and feeds the MEM/WB register.
module mem_stage_ws
    import arm_pkg::*;
#(
    parameter int DATA_W      = WORD_W,
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 2,
    parameter int BASE_ADDR   = DMEM_BASE
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wb_en_in,
    input  logic                  mem_r_en_in,
    input  logic                  mem_w_en_in,
    input  logic [DATA_W-1:0]     alu_res_in,
    input  logic [DATA_W-1:0]     val_rm_in,
    input  logic [REG_ADDR_W-1:0] dest_in,
    output logic                  ready,
    output logic                  addr_err,
    output logic                  wb_wb_en,
    output logic                  wb_mem_r_en,
    output logic [DATA_W-1:0]     wb_alu_res,
    output logic [DATA_W-1:0]     wb_mem_data,
    output logic [REG_ADDR_W-1:0] wb_dest
);
    localparam int            AW      = $clog2(DEPTH);
    localparam logic [3:0]    WAIT_C  = 4'(WAIT_CYCLES);
    localparam logic [DATA_W:0] ADDR_LO = (DATA_W+1)'(BASE_ADDR);
    localparam logic [DATA_W:0] ADDR_HI = (DATA_W+1)'(BASE_ADDR + 4 * DEPTH);

    mem_state_t        state, state_nxt;
    logic [3:0]        cnt, cnt_nxt;
    logic              req, complete, in_range, we;
    logic [AW-1:0]     idx;
    logic [DATA_W-1:0] rdata, ld_data;

    assign req      = mem_r_en_in | mem_w_en_in;
    assign ready    = !req || (cnt == WAIT_C);
    assign complete = req && ready;

    // Range check done one bit wider so BASE_ADDR + 4*DEPTH cannot wrap.
    assign in_range = ({1'b0, alu_res_in} >= ADDR_LO) && ({1'b0, alu_res_in} < ADDR_HI);
    assign idx      = AW'((alu_res_in - DATA_W'(BASE_ADDR)) >> 2);

    // A store landing while reset is held must not reach the array.
    assign we       = complete && mem_w_en_in && in_range && rst;
    assign ld_data  = (mem_r_en_in && in_range) ? rdata : '0;

    dmem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_dmem (
        .clk   (clk),
        .we    (we),
        .addr  (idx),
        .wdata (val_rm_in),
        .rdata (rdata)
    );

    // ready covers both "no request" and "access completes": either way the
    // counter clears, so back-to-back accesses each pay the full latency.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (ready) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end else if (state == IDLE) begin
            state_nxt = WAIT;
            cnt_nxt   = 4'd1;
        end else begin
            cnt_nxt   = cnt + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            cnt         <= '0;
            addr_err    <= 1'b0;
            wb_wb_en    <= 1'b0;
            wb_mem_r_en <= 1'b0;
            wb_alu_res  <= '0;
            wb_mem_data <= '0;
            wb_dest     <= '0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            addr_err <= complete && !in_range;
            if (ready) begin
                wb_wb_en    <= wb_en_in;
                wb_mem_r_en <= mem_r_en_in;
                wb_alu_res  <= alu_res_in;
                wb_mem_data <= ld_data;
                wb_dest     <= dest_in;
            end else begin
                wb_wb_en    <= 1'b0;
                wb_mem_r_en <= 1'b0;
            end
        end
    end
endmodule

// File: doc/mem_stage_ws.md
# mem_stage_ws

Parametrised memory stage for the five-stage ARM pipeline, successor to the single-cycle data-memory-plus-MEM/WB-register arrangement. Contains the data-memory array, a wait-state sequencer, and the MEM/WB pipeline register.
- Emulates a backing memory with a configurable access latency.
- Drops `ready` to freeze IF/ID/EXE while an access is pending.
- Inserts WB bubbles during the stall so no instruction retires twice.

## Interface
Parameters:
- `DATA_W`, 32, data word width.
- `DEPTH`, 64, number of words in the array (power of two).
- `WAIT_CYCLES`, 2, stall cycles per load/store (0..15); 0 gives single-cycle behaviour.
- `BASE_ADDR`, 1024, byte address of word 0.

Ports:
- Reset convention (already decided): one clock `clk`; reset `rst` is asynchronous, active-low.
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous active-low reset.
- `wb_en_in` in 1: EXE/MEM register write-back enable.
- `mem_r_en_in` in 1: load request.
- `mem_w_en_in` in 1: store request.
- `alu_res_in` in DATA_W: byte address for loads/stores; result for ALU ops.
- `val_rm_in` in DATA_W: store data.
- `dest_in` in 4: destination register.
- `ready` out 1: 0 means freeze every upstream stage and the EXE/MEM register.
- `addr_err` out 1: one-cycle pulse when an access completes out of range.
- `wb_wb_en` out 1: MEM/WB write-back enable.
- `wb_mem_r_en` out 1: MEM/WB select for load data.
- `wb_alu_res` out DATA_W: MEM/WB ALU result.
- `wb_mem_data` out DATA_W: MEM/WB load data.
- `wb_dest` out 4: MEM/WB destination register.

## Operation
Request and completion:
- `req = mem_r_en_in | mem_w_en_in`.
- `ready` is combinational: `!req || cnt == WAIT_CYCLES`.

Wait counter `cnt` (4 bits), FSM states IDLE and WAIT:
- IDLE with `req` and `WAIT_CYCLES > 0`: go to WAIT, `cnt ← 1`.
- WAIT with `cnt < WAIT_CYCLES`: `cnt ← cnt + 1`.
- Completing edge (`req && ready`): return to IDLE, `cnt ← 0`.
- No request: stay in IDLE, `cnt` stays 0.

Address decode:
- `idx = (alu_res_in - BASE_ADDR) >> 2`.
- Low two address bits are ignored.
- In range means `BASE_ADDR ≤ alu_res_in < BASE_ADDR + 4·DEPTH`.

Accesses, all taken on the completing edge:
- Store: array[idx] ← `val_rm_in`.
- Load: `wb_mem_data` ← array[idx], the asynchronous read of the pre-write value.
- Both read and write asserted: the write is performed and `wb_mem_data` returns the old value. Defined behaviour, not an error.
- Out of range: the write is dropped, load data is 0, and `addr_err` pulses for 1 cycle aligned with the MEM/WB update.

MEM/WB register, loaded every cycle:
- `ready` = 1: capture `wb_en_in`, `mem_r_en_in`, `alu_res_in`, load data, `dest_in`.
- `ready` = 0: bubble. `wb_wb_en` ← 0 and `wb_mem_r_en` ← 0; the other fields hold.
- Inputs are held stable by the frozen upstream while `ready` = 0. If they change mid-wait, the access that completes is the one present on the completing edge.

Reset (`rst` low, asynchronous):
- State IDLE, `cnt` = 0, `addr_err` = 0.
- All `wb_*` outputs = 0.
- A pending access is discarded; its store does not happen.
- Array contents are not reset.
- `ready` follows its combinational equation immediately.

## Timing
- Load or store occupying MEM from cycle t: `ready` is low during t .. t+WAIT_CYCLES−1 and high in t+WAIT_CYCLES.
- MEM/WB outputs are valid from t+WAIT_CYCLES+1.
- With `WAIT_CYCLES` = 0: no stall; latency matches the single-cycle stage.
- Non-memory instructions: `ready` = 1, one-cycle pass-through.
- Back-to-back memory ops: each incurs the full WAIT_CYCLES stall. There is no overlap, because the counter returns to 0 on every completion.
- `cnt` never exceeds WAIT_CYCLES. Its width is sized for the 15-cycle maximum.

## Structure
- Shared package `arm_pkg`: `WORD_W` = 32, `REG_ADDR_W` = 4, `DMEM_BASE` = 1024, FSM state enum `mem_state_t` {IDLE, WAIT}.
- One sub-module `dmem_array`:
  - DEPTH × DATA_W array.
  - Synchronous write with write-enable.
  - Asynchronous read.
  - No reset.
- Sequencer, decode and MEM/WB register live in `mem_stage_ws`.
- Pipeline top change: `ready` is ANDed into the existing hazard freeze, which gates the PC, the IF/ID and ID/EXE registers, and the EXE/MEM register.

## Test plan
- Store then load, WAIT_CYCLES=2, addr 1024, data 0xDEADBEEF:
  - `ready` low for 2 cycles on each access.
  - Load gives `wb_mem_data` = 0xDEADBEEF, `wb_mem_r_en` = 1.
  - `wb_wb_en` is 0 during both stall cycles.
- WAIT_CYCLES=0, ALU op then store/load at 1028:
  - `ready` is never low.
  - Every instruction reaches MEM/WB one cycle after MEM.
- Out-of-range store at 1024+4·DEPTH, then load at the same address:
  - Array is unchanged.
  - Load returns 0.
  - `addr_err` pulses once for each access.
- Simultaneous read+write at 1032, old value 0x11, new value 0x22:
  - `wb_mem_data` = 0x11.
  - A following load returns 0x22.
- `rst` low mid-wait on a store to 1036 (old value 0x5):
  - All outputs go to 0 immediately; state returns to IDLE.
  - A later load returns 0x5 (store discarded).
- Non-memory op with `wb_en_in`=1, `dest_in`=7, `alu_res_in`=0x1234 directly after a load stall:
  - Appears in MEM/WB exactly once.
  - `wb_dest` = 7, `wb_alu_res` = 0x1234.
